// File: rtl/mul_float_pkg.sv
// Shared constants and FSM encoding for the iterative floating-point multiplier.
package mul_float_pkg;

  localparam int unsigned EW_DEF   = 8;
  localparam int unsigned MW_DEF   = 23;
  localparam int unsigned BIAS_DEF = (1 << (EW_DEF - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul_float_round.sv
// Combinational normalise, round-to-nearest-even, exponent range check and
// special-operand packing for the raw significand product.
module mul_float_round #(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23
) (
  input  logic              sign_i,
  input  logic [EW-1:0]     ea_i,
  input  logic [EW-1:0]     eb_i,
  input  logic              a_fnz_i,
  input  logic              b_fnz_i,
  input  logic [2*MW+1:0]   prod_i,
  output logic [EW+MW:0]    c_c,
  output logic              overflow_c,
  output logic              underflow_c
);

  localparam int unsigned W  = 1 + EW + MW;
  localparam int unsigned XW = EW + 2;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EW) - 1);

  logic            norm;
  logic [MW-1:0]   frac;
  logic            guard;
  logic            sticky;
  logic            inc;
  logic [MW:0]     frac_r;
  logic [XW-1:0]   e_u;
  logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign norm = prod_i[2*MW+1];

  // Product lies in [1,4): pick the fraction window below the leading one.
  always_comb begin
    frac   = prod_i[2*MW-1:MW];
    guard  = prod_i[MW-1];
    sticky = |prod_i[MW-2:0];
    if (norm) begin
      frac   = prod_i[2*MW:MW+1];
      guard  = prod_i[MW];
      sticky = |prod_i[MW-1:0];
    end
  end

  assign inc    = guard & (sticky | frac[0]);
  assign frac_r = {1'b0, frac} + (MW+1)'(inc);
  assign e_u    = {2'b00, ea_i} + {2'b00, eb_i} - BIAS + XW'(norm) + XW'(frac_r[MW]);

  assign a_zero = (ea_i == '0);
  assign b_zero = (eb_i == '0);
  assign a_inf  = (&ea_i) & ~a_fnz_i;
  assign b_inf  = (&eb_i) & ~b_fnz_i;
  assign a_nan  = (&ea_i) & a_fnz_i;
  assign b_nan  = (&eb_i) & b_fnz_i;

  // A rounding carry leaves frac_r[MW-1:0] at zero, so no explicit clear is needed.
  always_comb begin
    c_c         = {sign_i, e_u[EW-1:0], frac_r[MW-1:0]};
    overflow_c  = 1'b0;
    underflow_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      c_c = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    end else if (a_inf || b_inf) begin
      c_c = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
    end else if (a_zero || b_zero) begin
      c_c = {sign_i, (W-1)'(0)};
    end else if ($signed(e_u) >= $signed(EMAX)) begin
      c_c        = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
      overflow_c = 1'b1;
    end else if (e_u[XW-1] || (e_u == '0)) begin
      c_c         = {sign_i, (W-1)'(0)};
      underflow_c = 1'b1;
    end
  end

endmodule

// File: rtl/mul_float_iter.sv
// Iterative IEEE-754-style multiplier: one multiplier bit per cycle, then a
// single normalise/round cycle, with a valid/ready handshake on both sides.
module mul_float_iter
  import mul_float_pkg::*;
#(
  parameter int unsigned EW = EW_DEF,
  parameter int unsigned MW = MW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+MW:0]    a,
  input  logic [EW+MW:0]    b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW:0]    c,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned W  = 1 + EW + MW;
  localparam int unsigned N  = MW + 1;
  localparam int unsigned CW = $clog2(MW + 2);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic            sign_q, sign_d;
  logic [EW-1:0]   ea_q, ea_d, eb_q, eb_d;
  logic            a_fnz_q, a_fnz_d, b_fnz_q, b_fnz_d;
  logic [W-1:0]    c_q, c_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [N:0]      sum;
  logic [W-1:0]    rnd_c;
  logic            rnd_ovf, rnd_unf;

  assign sum = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : (N+1)'(0));

  mul_float_round #(.EW(EW), .MW(MW)) u_round (
    .sign_i      (sign_q),
    .ea_i        (ea_q),
    .eb_i        (eb_q),
    .a_fnz_i     (a_fnz_q),
    .b_fnz_i     (b_fnz_q),
    .prod_i      (acc_q),
    .c_c         (rnd_c),
    .overflow_c  (rnd_ovf),
    .underflow_c (rnd_unf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    a_fnz_d  = a_fnz_q;
    b_fnz_d  = b_fnz_q;
    c_d      = c_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d   = a[W-1] ^ b[W-1];
          ea_d     = a[W-2:MW];
          eb_d     = b[W-2:MW];
          a_fnz_d  = |a[MW-1:0];
          b_fnz_d  = |b[MW-1:0];
          mcand_d  = {|a[W-2:MW], a[MW-1:0]};
          mplier_d = {|b[W-2:MW], b[MW-1:0]};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end
      end
      // Shift-add, LSB first; the carry of the upper-half add shifts in at the top.
      MUL: begin
        acc_d    = {sum, acc_q[N-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MW)) state_d = NORM;
      end
      NORM: begin
        c_d     = rnd_c;
        ovf_d   = rnd_ovf;
        unf_d   = rnd_unf;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      a_fnz_q     <= 1'b0;
      b_fnz_q     <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      a_fnz_q     <= a_fnz_d;
      b_fnz_q     <= b_fnz_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_mul_float_iter.sv
// Scoreboard bench for mul_float_iter with hand-computed single-precision vectors.
module tb_mul_float_iter;

  typedef struct {
    logic [31:0] c;
    logic        ovf;
    logic        unf;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        overflow;
  logic        underflow;

  exp_t sb[$];
  int   checks;
  int   errors;

  mul_float_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Wait for in_ready, present one operand pair for a single accepting edge.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                      input logic [31:0] ec, input logic eo, input logic eu,
                      input bit push, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_accept_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    if (push) sb.push_back('{c: ec, ovf: eo, unf: eu, name: name});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    exp_t e;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;

    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", c);
          end else begin
            e = sb.pop_front();
            check({e.name, "_c"}, c, e.c);
            check({e.name, "_ovf"}, 32'(overflow), 32'(e.ovf));
            check({e.name, "_unf"}, 32'(underflow), 32'(e.unf));
          end
        end
      end
    join_none

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", c, 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b1, "mul_1p5x2");
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 60);
    check("latency_edges", 32'(n), 32'd25);

    send(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 1'b1, "neg2x3");
    send(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 1'b1, "sticky_down");
    send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0, 1'b1, "tie_odd_up");
    send(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0, 1'b1, "max_frac_sq");
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 1'b1, "ovf");
    send(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b1, "unf");
    send(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b1, "inf_x_zero");
    send(32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 1'b0, 1'b1, "negzero_x3");
    send(32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0, 1'b1, "inf_x_neg2");
    send(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1, "nan_in");

    // Back-pressure: result must hold while out_ready is low and new operands are ignored.
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    send(32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0, 1'b1, "stall_9");
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_c", c, 32'h41100000);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = i[0];
      a = 32'h40000000;
      b = 32'h40000000;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of MUL abandons the operation.
    send(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 1'b0, "aborted");
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_c", c, 32'h0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_unf", 32'(underflow), 32'd0);
    #7 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    send(32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 1'b1, "after_rst");

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
